// File: rtl/io_bcd_display.sv
// Seven-segment output stage for the I/O ports: one shared double-dabble engine
// converts the two switch operands and the output port, then commits all six digits at once.
module io_bcd_display #(
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned OUT_MAX        = 99
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  in_port0,
    input  logic [3:0]  in_port1,
    input  logic [31:0] out_port0,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        busy
);
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned BIN_W  = 8;
    localparam int unsigned SR_W   = 2 * DIG_W + BIN_W;
    localparam int unsigned IT_W   = 3;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned IN_W   = 4;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned NUM_HEX = 6;

    localparam logic [OP_W-1:0]  LAST_OP   = OP_W'(2);
    localparam logic [IT_W-1:0]  LAST_IT   = IT_W'(7);
    localparam logic [DIG_W-1:0] DIG_DASH  = DIG_W'(10);
    localparam logic [DIG_W-1:0] DIG_BLANK = DIG_W'(15);
    localparam logic [SEG_W-1:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STORE = 2'd2
    } state_t;

    // Digit (0..9, dash, blank) to segment pattern, gfedcba, polarity applied.
    function automatic logic [SEG_W-1:0] seg_code(input logic [DIG_W-1:0] d);
        logic [SEG_W-1:0] al;
        case (d)
            4'd0:     al = 7'b1000000;
            4'd1:     al = 7'b1111001;
            4'd2:     al = 7'b0100100;
            4'd3:     al = 7'b0110000;
            4'd4:     al = 7'b0011001;
            4'd5:     al = 7'b0010010;
            4'd6:     al = 7'b0000010;
            4'd7:     al = 7'b1111000;
            4'd8:     al = 7'b0000000;
            4'd9:     al = 7'b0010000;
            DIG_DASH: al = 7'b0111111;
            default:  al = 7'b1111111;
        endcase
        return SEG_ACTIVE_LOW ? al : ~al;
    endfunction

    // One double-dabble iteration: add 3 to BCD nibbles >= 5, then shift left.
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
        logic [DIG_W-1:0] tens;
        logic [DIG_W-1:0] ones;
        tens = v[SR_W-1 -: DIG_W];
        ones = v[SR_W-DIG_W-1 -: DIG_W];
        if (tens >= DIG_W'(5)) tens = tens + DIG_W'(3);
        if (ones >= DIG_W'(5)) ones = ones + DIG_W'(3);
        return {tens[DIG_W-2:0], ones, v[BIN_W-1:0], 1'b0};
    endfunction

    state_t                        state_q, state_d;
    logic [OP_W-1:0]               op_q, op_d;
    logic [IT_W-1:0]               it_q, it_d;
    logic [SR_W-1:0]               sr_q, sr_d;
    logic [IN_W-1:0]               snap0_q, snap0_d;
    logic [IN_W-1:0]               snap1_q, snap1_d;
    logic [OUT_W-1:0]              snapo_q, snapo_d;
    logic                          force_q, force_d;
    logic [3:0][DIG_W-1:0]         stage_q, stage_d;
    logic [NUM_HEX-1:0][SEG_W-1:0] hex_q, hex_d;
    logic                          busy_q, busy_d;

    logic                          changed;
    logic                          out_over;
    logic [DIG_W-1:0]              res_tens;
    logic [DIG_W-1:0]              res_ones;
    logic [SR_W-1:0]               next_load;

    assign changed  = ({in_port0, in_port1, out_port0} != {snap0_q, snap1_q, snapo_q});
    assign out_over = (snapo_q > OUT_W'(OUT_MAX));
    assign res_tens = sr_q[SR_W-1 -: DIG_W];
    assign res_ones = sr_q[SR_W-DIG_W-1 -: DIG_W];
    // Only operands 1 and 2 are ever loaded from STORE; operand 2 uses the low byte.
    assign next_load = (op_q == OP_W'(0)) ? {(2 * DIG_W)'(0), (BIN_W - IN_W)'(0), snap1_q}
                                          : {(2 * DIG_W)'(0), snapo_q[BIN_W-1:0]};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            op_q    <= '0;
            it_q    <= '0;
            sr_q    <= '0;
            snap0_q <= '0;
            snap1_q <= '0;
            snapo_q <= '0;
            force_q <= 1'b1;
            stage_q <= '0;
            hex_q   <= {NUM_HEX{SEG_BLANK}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            it_q    <= it_d;
            sr_q    <= sr_d;
            snap0_q <= snap0_d;
            snap1_q <= snap1_d;
            snapo_q <= snapo_d;
            force_q <= force_d;
            stage_q <= stage_d;
            hex_q   <= hex_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        it_d    = it_q;
        sr_d    = sr_q;
        snap0_d = snap0_q;
        snap1_d = snap1_q;
        snapo_d = snapo_q;
        force_d = force_q;
        stage_d = stage_q;
        hex_d   = hex_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (force_q || changed) begin
                    snap0_d = in_port0;
                    snap1_d = in_port1;
                    snapo_d = out_port0;
                    force_d = 1'b0;
                    busy_d  = 1'b1;
                    op_d    = '0;
                    it_d    = '0;
                    sr_d    = {(2 * DIG_W)'(0), (BIN_W - IN_W)'(0), in_port0};
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d = dabble(sr_q);
                it_d = it_q + IT_W'(1);
                if (it_q == LAST_IT) state_d = STORE;
            end
            STORE: begin
                if (op_q != LAST_OP) begin
                    if (op_q == OP_W'(0)) stage_d[3:2] = {res_tens, res_ones};
                    else                  stage_d[1:0] = {res_tens, res_ones};
                    op_d    = op_q + OP_W'(1);
                    it_d    = '0;
                    sr_d    = next_load;
                    state_d = SHIFT;
                end else begin
                    // Last operand goes straight to the display alongside the staged digits.
                    hex_d[5] = seg_code(stage_q[3]);
                    hex_d[4] = seg_code(stage_q[2]);
                    hex_d[3] = seg_code(stage_q[1]);
                    hex_d[2] = seg_code(stage_q[0]);
                    hex_d[1] = seg_code(out_over ? DIG_DASH : res_tens);
                    hex_d[0] = seg_code(out_over ? DIG_DASH : res_ones);
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign busy = busy_q;

endmodule

// File: tb/tb_io_bcd_display.sv
// Bench for io_bcd_display: round-level display model checked every cycle on both
// segment polarities, plus literal spot checks of committed patterns.
module tb_io_bcd_display;
    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  in_port0;
    logic [3:0]  in_port1;
    logic [31:0] out_port0;
    logic [6:0]  ha [6];
    logic [6:0]  hn [6];
    logic        busy_a;
    logic        busy_n;

    int checks = 0;
    int errors = 0;

    localparam int LATENCY = 27;
    localparam int OMAX    = 99;
    localparam int DASH    = 10;
    localparam int BLANK   = 11;

    always #5 clock = ~clock;

    io_bcd_display u_dut (
        .clock(clock), .resetn(resetn),
        .in_port0(in_port0), .in_port1(in_port1), .out_port0(out_port0),
        .hex0(ha[0]), .hex1(ha[1]), .hex2(ha[2]), .hex3(ha[3]), .hex4(ha[4]), .hex5(ha[5]),
        .busy(busy_a)
    );

    io_bcd_display #(.SEG_ACTIVE_LOW(1'b0), .OUT_MAX(99)) u_dut_n (
        .clock(clock), .resetn(resetn),
        .in_port0(in_port0), .in_port1(in_port1), .out_port0(out_port0),
        .hex0(hn[0]), .hex1(hn[1]), .hex2(hn[2]), .hex3(hn[3]), .hex4(hn[4]), .hex5(hn[5]),
        .busy(busy_n)
    );

    logic [41:0] all_a;
    logic [41:0] all_n;
    assign all_a = {ha[5], ha[4], ha[3], ha[2], ha[1], ha[0]};
    assign all_n = {hn[5], hn[4], hn[3], hn[2], hn[1], hn[0]};

    function automatic logic [6:0] seg_of(input int d, input bit al);
        logic [6:0] c;
        case (d)
            0: c = 7'b1000000;
            1: c = 7'b1111001;
            2: c = 7'b0100100;
            3: c = 7'b0110000;
            4: c = 7'b0011001;
            5: c = 7'b0010010;
            6: c = 7'b0000010;
            7: c = 7'b1111000;
            8: c = 7'b0000000;
            9: c = 7'b0010000;
            DASH: c = 7'b0111111;
            default: c = 7'b1111111;
        endcase
        return al ? c : ~c;
    endfunction

    // Round-level model: a round is 27 edges after the capture edge, then all digits appear.
    int          exp_dig [6];
    bit          exp_busy = 1'b0;
    int          remaining = 0;
    bit          mforce = 1'b1;
    logic [3:0]  m_in0 = '0;
    logic [3:0]  m_in1 = '0;
    logic [31:0] m_out = '0;
    bit          model_valid = 1'b0;

    always @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 6; i++) exp_dig[i] <= BLANK;
            exp_busy  <= 1'b0;
            remaining <= 0;
            mforce    <= 1'b1;
            m_in0     <= '0;
            m_in1     <= '0;
            m_out     <= '0;
        end else if (remaining != 0) begin
            remaining <= remaining - 1;
            if (remaining == 1) begin
                exp_busy   <= 1'b0;
                exp_dig[5] <= int'(m_in0) / 10;
                exp_dig[4] <= int'(m_in0) % 10;
                exp_dig[3] <= int'(m_in1) / 10;
                exp_dig[2] <= int'(m_in1) % 10;
                exp_dig[1] <= (m_out > OMAX) ? DASH : int'(m_out) / 10;
                exp_dig[0] <= (m_out > OMAX) ? DASH : int'(m_out) % 10;
            end
        end else if (mforce || in_port0 != m_in0 || in_port1 != m_in1 || out_port0 != m_out) begin
            m_in0     <= in_port0;
            m_in1     <= in_port1;
            m_out     <= out_port0;
            mforce    <= 1'b0;
            exp_busy  <= 1'b1;
            remaining <= LATENCY;
        end
        model_valid <= 1'b1;
    end

    function automatic logic [41:0] exp_hex(input bit al);
        return {seg_of(exp_dig[5], al), seg_of(exp_dig[4], al), seg_of(exp_dig[3], al),
                seg_of(exp_dig[2], al), seg_of(exp_dig[1], al), seg_of(exp_dig[0], al)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (model_valid) begin
            check("hex_active_low", 64'(all_a), 64'(exp_hex(1'b1)));
            check("hex_active_high", 64'(all_n), 64'(exp_hex(1'b0)));
            check("busy_active_low", 64'(busy_a), 64'(exp_busy));
            check("busy_active_high", 64'(busy_n), 64'(exp_busy));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S7 = 7'b1111000, S9 = 7'b0010000, SD = 7'b0111111,
                           SB = 7'b1111111;

    initial begin
        resetn = 1'b0; in_port0 = 4'd0; in_port1 = 4'd0; out_port0 = 32'd0;
        step(2);
        check("lit_reset_blank", 64'(all_a), 64'({6{SB}}));
        check("lit_reset_blank_inv", 64'(all_n), 64'({6{7'b0000000}}));
        resetn = 1'b1;
        step(28);
        check("lit_forced_zero", 64'(all_a), 64'({6{S0}}));
        check("lit_forced_busy", 64'(busy_a), 64'(1'b0));

        in_port0 = 4'd9; in_port1 = 4'd15; out_port0 = 32'd42;
        step(28);
        check("lit_09_15_42", 64'(all_a), 64'({S0, S9, S1, S5, S4, S2}));

        out_port0 = 32'd99;
        step(28);
        check("lit_out_99", 64'(all_a), 64'({S0, S9, S1, S5, S9, S9}));
        out_port0 = 32'd100;
        step(28);
        check("lit_out_100_dash", 64'(all_a), 64'({S0, S9, S1, S5, SD, SD}));
        out_port0 = 32'h8000_0005;
        step(28);
        check("lit_out_hibit_dash", 64'(all_a), 64'({S0, S9, S1, S5, SD, SD}));

        in_port0 = 4'd3;
        step(5);
        in_port0 = 4'd7;
        step(23);
        check("lit_first_round_03", 64'({ha[5], ha[4]}), 64'({S0, S3}));
        step(28);
        check("lit_second_round_07", 64'({ha[5], ha[4]}), 64'({S0, S7}));

        in_port1 = 4'd5;
        step(15);
        resetn = 1'b0;
        step(1);
        check("lit_midround_reset", 64'({all_a, busy_a}), 64'({{6{SB}}, 1'b0}));
        resetn = 1'b1;
        step(28);
        check("lit_after_reset_round", 64'(all_a), 64'({S0, S7, S0, S5, SD, SD}));

        in_port1 = 4'd8;
        step(28);
        check("lit_eight_al", 64'(ha[2]), 64'(7'b0000000));
        check("lit_eight_ah", 64'(hn[2]), 64'(7'b1111111));
        step(200);
        check("lit_idle_busy", 64'({busy_a, busy_n}), 64'(2'b00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
